data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised byte-addressed data memory for the KGP-RISC load/store stage.
//  Supports byte/half/word accesses with lane placement and sign/zero extension.
//  One-cycle registered read, with a req/ready handshake.
//  After reset, a hardware clear walk zeroes the array; no for-loop reset of storage.
// PARAMETERS
//  ADDR_W          12  byte-address width; DEPTH = 2**(ADDR_W-2) 32-bit words
//  CLEAR_ON_RESET  1   1: run CLEAR walk after reset; 0: go straight to IDLE, contents undefined
// PORTS
//  clk       in   1       rising-edge clock
//  reset_n   in   1       asynchronous active-low reset
//  req       in   1       access request, sampled when ready=1
//  we        in   1       1=store, 0=load (qualified by req)
//  size      in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  sign_ext  in   1       loads only: 1 sign-extend, 0 zero-extend
//  addr      in   ADDR_W  byte address; word index = addr[ADDR_W-1:2]
//  wdata     in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  ready     out  1       1 = accepts req this cycle
//  rvalid    out  1       one-cycle pulse: rdata valid (loads only)
//  rdata     out  32      extended load result, held until next rvalid
//  err       out  1       misaligned-access pulse (tied 0 without macro)
// BEHAVIOUR
//  - Reset (reset_n=0, async): ready=0, rvalid=0, err=0, rdata=0, clear_ptr=0.
//    State -> CLEAR if CLEAR_ON_RESET, else IDLE.
//  - FSM: CLEAR -> IDLE when clear_ptr==DEPTH-1. IDLE is the only state accepting requests.
//  - CLEAR: writes 0 to word clear_ptr each cycle; clear_ptr++.
//    ready=0 for exactly DEPTH cycles. req is ignored, never queued.
//  - IDLE: ready=1. Accept = req & ready; one access per cycle, back-to-back allowed.
//  - Load accepted at edge N: rvalid=1 and rdata valid after edge N+1; rvalid=0 otherwise.
//    - Byte: lane addr[1:0] selected, extended to 32 bits.
//    - Half: lane addr[1] selected, extended to 32 bits.
//    - Word: returned as stored.
//  - Store accepted at edge N: only the addressed lanes are written at edge N; other lanes keep their value.
//    No rvalid. A load to the same word at N+1 returns the new data.
//  - Alignment without macro: low address bits are ignored.
//    Half uses addr[1] only; word ignores addr[1:0].
//  - rdata width rule: sign_ext copies bit 7 (byte) or bit 15 (half) upward. Word ignores sign_ext.
//  - Address wrap: ADDR_W bits only, so no out-of-range access exists.
//  - Reset asserted mid-CLEAR or mid-load: outputs return to reset values.
//    Any pending rvalid is dropped; CLEAR restarts at 0.
// CONFIGURATION
//  DMEM_MISALIGN_CHECK_EN defined:
//    - Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//    - Misaligned access: err=1 one cycle after accept (same timing as rvalid).
//    - Misaligned store: suppressed, memory unchanged.
//    - Misaligned load: rvalid=0, rdata unchanged.
//  DMEM_MISALIGN_CHECK_EN undefined: err tied 0; low-bit-ignore rule above applies.
// TESTING
//  1 reset_n low then high, CLEAR_ON_RESET=1, ADDR_W=6 -> ready=0 for 16 cycles, then 1.
//    Load any word -> 0x00000000.
//  2 store word 0xDEADBEEF @0x10, then load byte @0x13 sign_ext=1 -> rdata=0xFFFFFFDE.
//    Then load half @0x10 sign_ext=0 -> rdata=0x0000BEEF.
//  3 store byte 0x5A @0x11 over 0xDEADBEEF -> word load @0x10 = 0xDEAD5AEF.
//  4 back-to-back: store word 0x12345678 @0x20 at N, load @0x20 at N+1
//    -> rvalid at N+2, rdata=0x12345678.
//  5 reset_n pulsed low at CLEAR cycle 5 -> ready stays 0 a full DEPTH cycles after release.
//    Pending rvalid is never seen.
//  6 (macro on) store word 0xFFFFFFFF @0x22 -> err pulse, rvalid=0.
//    Load @0x20 unchanged; (macro off) same store writes word @0x20.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressed data memory for the load/store stage
//
// Byte/half/word loads and stores with lane placement and sign/zero extension.
// Loads return one cycle after acceptance (rvalid pulse); stores write at the
// accepting edge. After reset an optional hardware walk zeroes every word.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned accesses flagged
// on err and suppressed; otherwise low address bits are ignored, err tied 0).
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req       access request, taken when ready=1
//   we        1 store, 0 load
//   size      00 byte, 01 half, 10/11 word
//   sign_ext  loads: 1 sign-extend, 0 zero-extend
//   addr      byte address, word index addr[ADDR_W-1:2]
//   wdata     right-justified store data
//   ready     request accepted this cycle when high
//   rvalid    one-cycle pulse, rdata valid
//   rdata     extended load result, held between rvalid pulses
//   err       misaligned-access pulse
module data_memory_ctrl #(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state, next_state;
  logic [IW-1:0] clear_ptr, clear_ptr_nxt;
  logic          clear_we;

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] widx;
  logic          accept, misaligned, do_store, do_load;
  logic [3:0]    be;
  logic [31:0]   wword;

  logic          ld_pend;
  logic [1:0]    ld_lane;
  logic [1:0]    ld_size;
  logic          ld_sign;
  logic [31:0]   rd_word;
  logic [31:0]   ld_result;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clear_ptr <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= next_state;
      clear_ptr <= clear_ptr_nxt;
      // Registered so ready is low during reset even when no clear walk runs.
      ready     <= (next_state == S_IDLE);
    end
  end

  always_comb begin
    next_state    = state;
    clear_ptr_nxt = clear_ptr;
    clear_we      = 1'b0;
    case (state)
      S_CLEAR: begin
        clear_we      = 1'b1;
        clear_ptr_nxt = clear_ptr + 1'b1;
        // All-ones pointer is the last word; leaving here makes CLEAR last DEPTH cycles.
        if (&clear_ptr) next_state = S_IDLE;
      end
      S_IDLE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------- request decode ----------------
  assign accept = req & ready;
  assign widx   = addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign do_store = accept & we & ~misaligned;
  assign do_load  = accept & ~we & ~misaligned;

  // Replicate the right-justified data across lanes; byte enables pick the target.
  always_comb begin
    be    = 4'b1111;
    wword = wdata;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wword = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
      end
    endcase
  end

  // ---------------- storage (no reset: cleared by the walk) ----------------
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_ptr] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_load) rd_word <= mem[widx];
  end

  // ---------------- load return path ----------------
  always_comb begin
    ld_result = rd_word;
    case (ld_size)
      2'b00: begin
        ld_result[7:0]  = rd_word[8*ld_lane +: 8];
        ld_result[31:8] = {24{ld_sign & ld_result[7]}};
      end
      2'b01: begin
        ld_result[15:0]  = ld_lane[1] ? rd_word[31:16] : rd_word[15:0];
        ld_result[31:16] = {16{ld_sign & ld_result[15]}};
      end
      default: ld_result = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_pend <= 1'b0;
      ld_lane <= 2'b00;
      ld_size <= 2'b00;
      ld_sign <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      ld_pend <= do_load;
      if (do_load) begin
        ld_lane <= addr[1:0];
        ld_size <= size;
        ld_sign <= sign_ext;
      end
      rvalid <= ld_pend;
      if (ld_pend) rdata <= ld_result;
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic err_pend;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Delayed twice so err lines up with where rvalid would have been.
      err_pend <= accept & misaligned;
      err      <= err_pend;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
